// File: rtl/syn_branch_predictor_if.sv
// Fetch/resolve port bundle for the branch predictor: IF-stage lookup,
// EX-stage training and debug statistics.
interface syn_branch_predictor_if #(
  parameter int AddrBits = 10
);
  logic                en;
  logic                tbl_clr;
  logic [AddrBits-1:0] pc_if;
  logic                hit;
  logic                predict_taken;
  logic [AddrBits-1:0] predict_target;
  logic                upd_valid;
  logic [AddrBits-1:0] upd_pc;
  logic                upd_taken;
  logic [AddrBits-1:0] upd_target;
  logic                upd_mispredict;
  logic [15:0]         branch_cnt;
  logic [15:0]         mispredict_cnt;

  modport master (
    output en, tbl_clr, pc_if, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
    input  hit, predict_taken, predict_target, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  en, tbl_clr, pc_if, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
    output hit, predict_taken, predict_target, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/syn_branch_predictor.sv
// Fully-associative BTB with 2-bit direction counters and true-LRU replacement.
// Combinational lookup on pc_if; training and statistics update on the clock edge.
module syn_branch_predictor #(
  parameter int AddrBits = 10,
  parameter int Entries  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  syn_branch_predictor_if.slave bus
);
  localparam int AgeW = (Entries > 1) ? $clog2(Entries) : 1;

  logic [Entries-1:0]                valid_q, valid_d;
  logic [Entries-1:0][AddrBits-1:0]  tag_q, tag_d;
  logic [Entries-1:0][AddrBits-1:0]  tgt_q, tgt_d;
  logic [Entries-1:0][1:0]           ctr_q, ctr_d;
  logic [Entries-1:0][AgeW-1:0]      age_q, age_d;
  logic [15:0]                       branch_cnt_q, branch_cnt_d;
  logic [15:0]                       mispredict_cnt_q, mispredict_cnt_d;

  logic            lk_hit;
  logic [AgeW-1:0] lk_idx;
  logic            upd_hit;
  logic [AgeW-1:0] upd_idx;
  logic            inv_found;
  logic [AgeW-1:0] inv_idx;
  logic [AgeW-1:0] lru_idx;
  logic [AgeW-1:0] vic_idx;
  logic            touch;
  logic [AgeW-1:0] touch_idx;
  logic [AgeW-1:0] old_age;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Lookup: tags are unique, so the last match found is the only match.
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    for (int i = 0; i < Entries; i++) begin
      if (valid_q[i] && tag_q[i] == bus.pc_if) begin
        lk_hit = 1'b1;
        lk_idx = AgeW'(i);
      end
    end
  end

  assign bus.hit            = lk_hit;
  assign bus.predict_taken  = lk_hit && ctr_q[lk_idx][1];
  assign bus.predict_target = bus.predict_taken ? tgt_q[lk_idx] : bus.pc_if + AddrBits'(1);
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispredict_cnt = mispredict_cnt_q;

  // Training-side match and victim selection (lowest invalid, else the LRU entry).
  always_comb begin
    upd_hit   = 1'b0;
    upd_idx   = '0;
    inv_found = 1'b0;
    inv_idx   = '0;
    lru_idx   = '0;
    for (int i = 0; i < Entries; i++) begin
      if (valid_q[i] && tag_q[i] == bus.upd_pc) begin
        upd_hit = 1'b1;
        upd_idx = AgeW'(i);
      end
      if (age_q[i] == AgeW'(Entries - 1)) lru_idx = AgeW'(i);
    end
    for (int i = Entries - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        inv_found = 1'b1;
        inv_idx   = AgeW'(i);
      end
    end
    vic_idx = inv_found ? inv_idx : lru_idx;
  end

  always_comb begin
    valid_d   = valid_q;
    tag_d     = tag_q;
    tgt_d     = tgt_q;
    ctr_d     = ctr_q;
    age_d     = age_q;
    touch     = 1'b0;
    touch_idx = '0;
    old_age   = '0;
    if (bus.en && bus.tbl_clr) begin
      valid_d = '0;
      for (int i = 0; i < Entries; i++) age_d[i] = AgeW'(i);
    end else if (bus.en && bus.upd_valid) begin
      if (upd_hit) begin
        ctr_d[upd_idx] = bus.upd_taken ? ctr_inc(ctr_q[upd_idx]) : ctr_dec(ctr_q[upd_idx]);
        if (bus.upd_taken) tgt_d[upd_idx] = bus.upd_target;
        touch     = 1'b1;
        touch_idx = upd_idx;
      end else if (bus.upd_taken) begin
        valid_d[vic_idx] = 1'b1;
        tag_d[vic_idx]   = bus.upd_pc;
        tgt_d[vic_idx]   = bus.upd_target;
        ctr_d[vic_idx]   = 2'b10;
        touch            = 1'b1;
        touch_idx        = vic_idx;
      end
    end
    // LRU touch keeps ages a permutation of 0..Entries-1.
    if (touch) begin
      old_age = age_q[touch_idx];
      for (int i = 0; i < Entries; i++) begin
        if (AgeW'(i) == touch_idx)  age_d[i] = '0;
        else if (age_q[i] < old_age) age_d[i] = age_q[i] + AgeW'(1);
      end
    end
  end

  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (bus.en && bus.upd_valid) begin
      branch_cnt_d = sat_inc16(branch_cnt_q);
      if (bus.upd_mispredict) mispredict_cnt_d = sat_inc16(mispredict_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q          <= '0;
      tag_q            <= '0;
      tgt_q            <= '0;
      ctr_q            <= '0;
      for (int i = 0; i < Entries; i++) age_q[i] <= AgeW'(i);
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      valid_q          <= valid_d;
      tag_q            <= tag_d;
      tgt_q            <= tgt_d;
      ctr_q            <= ctr_d;
      age_q            <= age_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end
endmodule
